// File: rtl/layer_argmax_sink.sv
// Consumes one M-word vector from a valid/ready stream, tracks the signed maximum and
// its earliest index, then offers {index, value} as a single result beat.
module layer_argmax_sink #(
  parameter int unsigned M    = 13,
  parameter int unsigned T    = 32,
  parameter int unsigned LOGM = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [T-1:0]    data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LOGM-1:0]        idx_out,
  output logic signed [T-1:0]    max_out
);

  typedef enum logic [0:0] {StCollect, StResult} state_e;

  localparam logic [LOGM-1:0] LastIdx = LOGM'(M - 1);

  state_e                state_q, state_d;
  logic [LOGM-1:0]       count_q, count_d;
  logic [LOGM-1:0]       best_idx_q, best_idx_d;
  logic signed [T-1:0]   best_val_q, best_val_d;
  logic [LOGM-1:0]       idx_q, idx_d;
  logic signed [T-1:0]   max_q, max_d;

  logic                  accept;
  logic                  take;
  logic                  last;
  logic [LOGM-1:0]       cand_idx;
  logic signed [T-1:0]   cand_val;

  always_comb begin
    s_ready    = (state_q == StCollect) && !reset;
    m_valid    = (state_q == StResult);
    accept     = s_valid && s_ready;
    // First word of a vector always seeds the best; later words win only on strict >.
    take       = (count_q == '0) || (data_in > best_val_q);
    last       = (count_q == LastIdx);
    cand_val   = take ? data_in : best_val_q;
    cand_idx   = take ? count_q : best_idx_q;

    state_d    = state_q;
    count_d    = count_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    idx_d      = idx_q;
    max_d      = max_q;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          best_val_d = cand_val;
          best_idx_d = cand_idx;
          if (last) begin
            count_d = '0;
            idx_d   = cand_idx;
            max_d   = cand_val;
            state_d = StResult;
          end else begin
            count_d = count_q + LOGM'(1);
          end
        end
      end
      StResult: begin
        if (m_ready) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StCollect;
      count_q    <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      idx_q      <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
    end
  end

  assign idx_out = idx_q;
  assign max_out = max_q;

endmodule

// File: tb/tb_layer_argmax_sink.sv
// Bench for layer_argmax_sink: transaction-level argmax model checked every cycle,
// plus literal expectations per directed vector.
module tb_layer_argmax_sink;

  localparam int M    = 13;
  localparam int T    = 32;
  localparam int LOGM = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [T-1:0]  data_in = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [LOGM-1:0]      idx_out;
  logic signed [T-1:0]  max_out;

  layer_argmax_sink #(.M(M), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
  endtask

  // Model: collect accepted words; once M are in, the result is pending until handshaked.
  int words[$];
  bit pending = 1'b0;
  int exp_idx = 0;
  int exp_max = 0;

  always @(posedge clk) begin
    if (reset) begin
      words.delete();
      pending = 1'b0;
    end else if (pending) begin
      if (m_ready) pending = 1'b0;
    end else if (s_valid) begin
      words.push_back(int'(data_in));
      if (words.size() == M) begin
        exp_idx = 0;
        exp_max = words[0];
        for (int k = 1; k < M; k++) begin
          if (words[k] > exp_max) begin
            exp_max = words[k];
            exp_idx = k;
          end
        end
        pending = 1'b1;
        words.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'b0, m_valid}, {31'b0, pending});
    chk("s_ready", {31'b0, s_ready}, {31'b0, !pending && !reset});
    if (pending) begin
      chk("idx_out", 32'(idx_out), exp_idx);
      chk("max_out", max_out, exp_max);
    end
  end

  // Drive the first n words of v; acceptance is decided from the model before each edge.
  task automatic send_vec(input int v[M], input int n, input bit gaps);
    int i = 0;
    int budget = 400;
    bit acc;
    while (i < n && budget > 0) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in = v[i];
      @(negedge clk);
      acc = s_valid && !pending && !reset;
      @(posedge clk);
      #1;
      if (acc) i++;
      budget--;
    end
    s_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  // Wait for a result beat (m_ready assumed 1), check literals, return cycles waited.
  task automatic wait_result(input string name, input int li, input int lm, output int waited);
    waited = 0;
    @(negedge clk);
    while (!m_valid && waited < 30) begin
      waited++;
      @(negedge clk);
    end
    if (!m_valid) chk({name, "_timeout"}, 32'(m_valid), 1);
    chk({name, "_idx"}, 32'(idx_out), li);
    chk({name, "_max"}, max_out, lm);
    @(posedge clk);
    #1;
  endtask

  int v[M];
  int w;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_idx", 32'(idx_out), 0);
    chk("rst_max", max_out, 0);
    @(posedge clk);
    #1;

    // 1) ascending, latency exactly one cycle after the last word
    for (int k = 0; k < M; k++) v[k] = k;
    send_vec(v, M, 1'b0);
    wait_result("t1", 12, 12, w);
    chk("t1_latency", w, 0);
    chk("t1_model_idx", exp_idx, 12);

    // 2) signed comparison
    for (int k = 0; k < M; k++) v[k] = -100;
    v[4] = -1;
    send_vec(v, M, 1'b0);
    wait_result("t2", 4, -1, w);
    chk("t2_model_max", exp_max, -1);

    // 3) tie keeps earliest index
    for (int k = 0; k < M; k++) v[k] = 0;
    v[2] = 7;
    v[9] = 7;
    send_vec(v, M, 1'b0);
    wait_result("t3", 2, 7, w);
    chk("t3_model_idx", exp_idx, 2);

    // 4) backpressure on the result while the next vector waits
    m_ready = 1'b0;
    for (int k = 0; k < M; k++) v[k] = k;
    v[6] = 999;
    send_vec(v, M, 1'b0);
    for (int k = 0; k < M; k++) v[k] = 100 - k;
    s_valid = 1'b1;
    data_in = v[0];
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(m_valid), 1);
      chk("t4_hold_ready", 32'(s_ready), 0);
      chk("t4_hold_idx", 32'(idx_out), 6);
      chk("t4_hold_max", max_out, 999);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send_vec(v, M, 1'b0);
    wait_result("t4", 0, 100, w);

    // 5) random input gaps
    for (int k = 0; k < M; k++) v[k] = int'($urandom_range(0, 59998)) - 29999;
    v[11] = 30000;
    send_vec(v, M, 1'b1);
    wait_result("t5", 11, 30000, w);

    // 6) reset mid-vector discards the partial vector
    for (int k = 0; k < M; k++) v[k] = 1000 + k;
    send_vec(v, 6, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < M; k++) v[k] = k * 10;
    v[0] = 500;
    send_vec(v, 7, 1'b0);
    @(negedge clk);
    chk("t6_no_spurious", 32'(m_valid), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) v[k] = v[k + 7];
    send_vec(v, 6, 1'b0);
    wait_result("t6", 0, 500, w);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
